// File: rtl/shared_data_mem.sv
// -----------------------------------------------------------------------------
// shared_data_mem
//
// One data array shared by CORE_COUNT processor cores. Each cycle at most one
// core request is granted. The granted core's write lands in the array at the
// closing edge. A granted read returns on rdData one cycle later, and the
// matching rdValid bit marks which core owns it. Per-core done pulses are
// collected into a sticky allDone.
//
// Configuration macro: SHARED_MEM_ROUND_ROBIN_EN
//   defined   : round-robin arbitration starting at a rotating pointer
//   undefined : fixed priority; the lowest-index requester always wins
//
// Ports
//   clk       in   single clock, rising edge
//   rstN      in   asynchronous reset, active low
//   req       in   [CORE_COUNT]            per-core access request
//   wrEn      in   [CORE_COUNT]            per-core write enable (qualified by req)
//   addr      in   [CORE_COUNT*ADDR_W]     packed addresses, core i in slice i
//   wrData    in   [CORE_COUNT*REG_WIDTH]  packed write data, core i in slice i
//   coreDone  in   [CORE_COUNT]            per-core done
//   grant     out  [CORE_COUNT]            one-hot combinational grant
//   rdData    out  [REG_WIDTH]             registered read data
//   rdValid   out  [CORE_COUNT]            one-hot owner of rdData
//   allDone   out                          sticky, every core has been done
//   busy      out                          any core requesting
// -----------------------------------------------------------------------------
module shared_data_mem #(
    parameter int CORE_COUNT          = 4,
    parameter int REG_WIDTH           = 12,
    parameter int DATA_MEM_DEPTH      = 4096,
    parameter int DATA_MEM_ADDR_WIDTH = $clog2(DATA_MEM_DEPTH)
) (
    input  logic                                      clk,
    input  logic                                      rstN,
    input  logic [CORE_COUNT-1:0]                     req,
    input  logic [CORE_COUNT-1:0]                     wrEn,
    input  logic [CORE_COUNT*DATA_MEM_ADDR_WIDTH-1:0] addr,
    input  logic [CORE_COUNT*REG_WIDTH-1:0]           wrData,
    input  logic [CORE_COUNT-1:0]                     coreDone,
    output logic [CORE_COUNT-1:0]                     grant,
    output logic [REG_WIDTH-1:0]                      rdData,
    output logic [CORE_COUNT-1:0]                     rdValid,
    output logic                                      allDone,
    output logic                                      busy
);

    localparam int AW    = DATA_MEM_ADDR_WIDTH;
    localparam int PTR_W = $clog2(CORE_COUNT);

    logic [CORE_COUNT-1:0] grantRaw;
    logic [AW-1:0]         selAddr;
    logic [REG_WIDTH-1:0]  selData;
    logic                  selWrEn;
    logic                  selInRange;
    logic [CORE_COUNT-1:0] doneSeen;

    logic [REG_WIDTH-1:0]  mem [DATA_MEM_DEPTH];

    // Isolate the lowest set bit: two's complement leaves only that bit in
    // common with the original vector.
    function automatic logic [CORE_COUNT-1:0] lowestSet(input logic [CORE_COUNT-1:0] v);
        return v & (~v + CORE_COUNT'(1));
    endfunction

`ifdef SHARED_MEM_ROUND_ROBIN_EN
    logic [PTR_W-1:0]      ptr;
    logic [PTR_W-1:0]      grantIdx;
    logic [CORE_COUNT-1:0] reqFromPtr;

    // Requests at or above ptr win first; if there are none, the search
    // wraps around to the lowest requesting index below ptr.
    always_comb begin
        reqFromPtr = req & ~((CORE_COUNT'(1) << ptr) - CORE_COUNT'(1));
        if (reqFromPtr != '0) begin
            grantRaw = lowestSet(reqFromPtr);
        end else begin
            grantRaw = lowestSet(req);
        end
    end

    always_comb begin
        grantIdx = '0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (grantRaw[i]) begin
                grantIdx = PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ptr <= '0;
        end else if (grant != '0) begin
            ptr <= (grantIdx == PTR_W'(CORE_COUNT - 1)) ? '0 : grantIdx + PTR_W'(1);
        end
    end
`else
    always_comb begin
        grantRaw = lowestSet(req);
    end
`endif

    assign grant = rstN ? grantRaw : '0;
    assign busy  = |req;

    // Grant is one-hot, so the last match is the only match.
    always_comb begin
        selAddr = '0;
        selData = '0;
        selWrEn = 1'b0;
        for (int i = 0; i < CORE_COUNT; i++) begin
            if (grant[i]) begin
                selAddr = addr[i*AW +: AW];
                selData = wrData[i*REG_WIDTH +: REG_WIDTH];
                selWrEn = wrEn[i];
            end
        end
    end

    // Depth need not be a power of two; addresses past the end read as zero
    // and their writes are dropped.
    assign selInRange = (32'(selAddr) < 32'(DATA_MEM_DEPTH));

    // ---- stage 0 -> 1: array write (contents survive reset) ----
    always_ff @(posedge clk) begin
        if ((grant != '0) && selWrEn && selInRange) begin
            mem[selAddr] <= selData;
        end
    end

    // ---- stage 0 -> 1: read response register ----
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            rdData  <= '0;
            rdValid <= '0;
        end else begin
            rdValid <= selWrEn ? '0 : grant;
            if ((grant != '0) && !selWrEn) begin
                rdData <= selInRange ? mem[selAddr] : '0;
            end
        end
    end

    // allDone looks at this cycle's coreDone as well, so it rises one cycle
    // after the final done pulse rather than two.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            doneSeen <= '0;
            allDone  <= 1'b0;
        end else begin
            doneSeen <= doneSeen | coreDone;
            allDone  <= allDone | (&(doneSeen | coreDone));
        end
    end

endmodule

// File: tb/tb_shared_data_mem.sv
// -----------------------------------------------------------------------------
// tb_shared_data_mem
//
// Scoreboarded bench for shared_data_mem. A reference model process computes
// the expected grant from the request vector each cycle, keeps a sparse copy
// of the array, and queues expected read responses. A separate monitor
// process pops the queue whenever rdValid is seen. Directed sequences cover
// reset, round trip, arbitration order, done collection and reset mid-read;
// a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_shared_data_mem;

    localparam int N     = 4;
    localparam int W     = 12;
    localparam int AWB   = 12;
    localparam int DEPTH = 3000;

    logic             clk;
    logic             rstN;
    logic [N-1:0]     req;
    logic [N-1:0]     wrEn;
    logic [N*AWB-1:0] addr;
    logic [N*W-1:0]   wrData;
    logic [N-1:0]     coreDone;
    logic [N-1:0]     grant;
    logic [W-1:0]     rdData;
    logic [N-1:0]     rdValid;
    logic             allDone;
    logic             busy;

    shared_data_mem #(
        .CORE_COUNT         (N),
        .REG_WIDTH          (W),
        .DATA_MEM_DEPTH     (DEPTH),
        .DATA_MEM_ADDR_WIDTH(AWB)
    ) dut (
        .clk     (clk),
        .rstN    (rstN),
        .req     (req),
        .wrEn    (wrEn),
        .addr    (addr),
        .wrData  (wrData),
        .coreDone(coreDone),
        .grant   (grant),
        .rdData  (rdData),
        .rdValid (rdValid),
        .allDone (allDone),
        .busy    (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int nTests = 0;
    int nFail  = 0;
    int cycle  = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int         core;
        logic [W-1:0] data;
        bit         known;
        int         due;
    } exp_t;

    exp_t         expQ[$];
    logic [W-1:0] mMem [int];
    int           mPtr;
    logic [N-1:0] mSeen;
    logic         mAllDone;
    int           gi;
    int           sc;
    logic [N-1:0] eg;
    logic [AWB-1:0] ma;
    exp_t         ne;

    always @(negedge clk) begin
        if (!rstN) begin
            mPtr     = 0;
            mSeen    = '0;
            mAllDone = 1'b0;
            expQ.delete();
            check("grant_in_reset", 32'(grant), 32'd0);
            check("allDone_in_reset", 32'(allDone), 32'd0);
        end else begin
            gi = -1;
            for (int k = 0; k < N; k++) begin
                sc = (mPtr + k) % N;
                if (gi < 0 && req[sc]) gi = sc;
            end
            eg = '0;
            if (gi >= 0) eg[gi] = 1'b1;
            check("grant", 32'(grant), 32'(eg));
            check("busy", 32'(busy), 32'(req != '0));
            check("allDone", 32'(allDone), 32'(mAllDone));
            if (gi >= 0) begin
                ma = addr[gi*AWB +: AWB];
                if (wrEn[gi]) begin
                    if (int'(ma) < DEPTH) mMem[int'(ma)] = wrData[gi*W +: W];
                end else begin
                    ne.core = gi;
                    ne.due  = cycle + 1;
                    if (int'(ma) >= DEPTH) begin
                        ne.data  = '0;
                        ne.known = 1'b1;
                    end else if (mMem.exists(int'(ma))) begin
                        ne.data  = mMem[int'(ma)];
                        ne.known = 1'b1;
                    end else begin
                        ne.data  = '0;
                        ne.known = 1'b0;
                    end
                    expQ.push_back(ne);
                end
`ifdef SHARED_MEM_ROUND_ROBIN_EN
                mPtr = (gi + 1) % N;
`endif
            end
            mAllDone = mAllDone | (&(mSeen | coreDone));
            mSeen    = mSeen | coreDone;
        end
    end

    // ---------------- monitor ----------------
    exp_t me;

    always @(negedge clk) begin
        if (rdValid != '0) begin
            if (expQ.size() == 0) begin
                check("rd_unexpected", 32'(rdValid), 32'd0);
            end else begin
                me = expQ.pop_front();
                check("rd_owner", 32'(rdValid), 32'(1) << me.core);
                if (me.known) check("rd_data", 32'(rdData), 32'(me.data));
            end
        end else if (expQ.size() > 0 && expQ[0].due < cycle) begin
            me = expQ.pop_front();
            check("rd_missing", 32'(rdValid), 32'(1) << me.core);
        end
    end

    // ---------------- stimulus ----------------
    task automatic setCore(input int c, input bit r, input bit we,
                           input logic [AWB-1:0] a, input logic [W-1:0] d);
        req[c]              = r;
        wrEn[c]             = we;
        addr[c*AWB +: AWB]  = a;
        wrData[c*W +: W]    = d;
    endtask

    task automatic doAccess(input int c, input bit we, input logic [AWB-1:0] a,
                            input logic [W-1:0] d,
                            output logic [W-1:0] rd, output logic [N-1:0] rv);
        int waited;
        @(posedge clk); #1;
        req = '0;
        setCore(c, 1'b1, we, a, d);
        waited = 0;
        @(negedge clk);
        while (!grant[c] && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!grant[c]) check("grant_timeout", 32'(grant[c]), 32'd1);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        rd = rdData;
        rv = rdValid;
    endtask

    function automatic logic [AWB-1:0] pickAddr();
        case ($urandom_range(0, 3))
            0, 1:    return AWB'($urandom_range(0, 15));
            2:       return AWB'($urandom_range(2990, 3009));
            default: return AWB'($urandom);
        endcase
    endfunction

    logic [W-1:0] rd;
    logic [N-1:0] rv;
    logic [N-1:0] lastGrant;
    logic [N-1:0] expG;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstN     = 1'b0;
        req      = '0;
        wrEn     = '0;
        addr     = '0;
        wrData   = '0;
        coreDone = '0;

        // Reset values with all cores requesting reads of address 0
        req = 4'b1111;
        repeat (2) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_rdValid", 32'(rdValid), 32'd0);
        check("rst_rdData", 32'(rdData), 32'd0);
        check("rst_allDone", 32'(allDone), 32'd0);

        // Release reset, then eight cycles of continuous requests
        @(posedge clk); #1;
        rstN = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
`ifdef SHARED_MEM_ROUND_ROBIN_EN
            expG = N'(1) << (k % N);
`else
            expG = 4'b0001;
`endif
            check("arb_sequence", 32'(grant), 32'(expG));
            @(posedge clk); #1;
        end
        req = '0;

        // Core 2 writes, core 1 reads the same address the very next cycle
        @(posedge clk); #1;
        setCore(2, 1'b1, 1'b1, 12'd100, 12'hABC);
        @(negedge clk);
        check("rt_wr_grant", 32'(grant), 32'b0100);
        @(posedge clk); #1;
        req = '0;
        wrEn = '0;
        setCore(1, 1'b1, 1'b0, 12'd100, 12'h000);
        @(negedge clk);
        check("rt_rd_grant", 32'(grant), 32'b0010);
        @(posedge clk); #1;
        req = '0;
        @(negedge clk);
        check("rt_rdValid", 32'(rdValid), 32'b0010);
        check("rt_rdData", 32'(rdData), 32'hABC);

        // Pointer now sits at 2: cores 1 and 3 requesting
        @(posedge clk); #1;
        setCore(1, 1'b1, 1'b0, 12'd100, 12'h000);
        setCore(3, 1'b1, 1'b0, 12'd100, 12'h000);
        @(negedge clk);
`ifdef SHARED_MEM_ROUND_ROBIN_EN
        check("skip_first", 32'(grant), 32'b1000);
`else
        check("skip_first", 32'(grant), 32'b0010);
`endif
        @(posedge clk); #1;
        @(negedge clk);
        check("skip_second", 32'(grant), 32'b0010);
        @(posedge clk); #1;
        req = '0;

        // Done bits one at a time in relative cycles 10, 12, 14 and 20
        for (int k = 0; k < 26; k++) begin
            @(posedge clk); #1;
            case (k)
                10:      coreDone = 4'b0001;
                12:      coreDone = 4'b0010;
                14:      coreDone = 4'b0100;
                20:      coreDone = 4'b1000;
                default: coreDone = 4'b0000;
            endcase
            @(negedge clk);
            check("done_timeline", 32'(allDone), 32'(k >= 21));
        end
        @(posedge clk); #1;
        coreDone = '0;
        rstN = 1'b0;
        #1;
        check("done_async_clear", 32'(allDone), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rstN = 1'b1;

        // Reset during an in-flight read response; array survives reset
        doAccess(0, 1'b1, 12'd5, 12'h5A5, rd, rv);
        @(posedge clk); #1;
        setCore(3, 1'b1, 1'b0, 12'd5, 12'h000);
        @(negedge clk);
        check("midrd_grant", 32'(grant), 32'b1000);
        @(posedge clk); #1;
        req = '0;
        check("midrd_pre_valid", 32'(rdValid), 32'b1000);
        rstN = 1'b0;
        #1;
        check("midrd_cancel", 32'(rdValid), 32'd0);
        check("midrd_data_clr", 32'(rdData), 32'd0);
        @(negedge clk);
        @(posedge clk); #1;
        rstN = 1'b1;
        doAccess(0, 1'b0, 12'd5, 12'h000, rd, rv);
        check("persist_valid", 32'(rv), 32'b0001);
        check("persist_data", 32'(rd), 32'h5A5);

        // Depth boundary: last word works, past the end reads zero
        doAccess(1, 1'b1, 12'd2999, 12'h123, rd, rv);
        doAccess(2, 1'b0, 12'd2999, 12'h000, rd, rv);
        check("edge_last_valid", 32'(rv), 32'b0100);
        check("edge_last_data", 32'(rd), 32'h123);
        doAccess(3, 1'b1, 12'd3000, 12'h777, rd, rv);
        doAccess(0, 1'b0, 12'd3000, 12'h000, rd, rv);
        check("oob_valid", 32'(rv), 32'b0001);
        check("oob_data", 32'(rd), 32'h000);
        doAccess(1, 1'b0, 12'd4095, 12'h000, rd, rv);
        check("oob_top_data", 32'(rd), 32'h000);

        // Randomized traffic; a core keeps its request until granted
        lastGrant = '0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (!req[i] || lastGrant[i]) begin
                    setCore(i, ($urandom_range(0, 1) == 1), ($urandom_range(0, 2) == 0),
                            pickAddr(), W'($urandom));
                end
            end
            coreDone = ($urandom_range(0, 15) == 0) ? N'(1 << $urandom_range(0, 3)) : '0;
            @(negedge clk);
            lastGrant = grant;
        end
        @(posedge clk); #1;
        req = '0;
        coreDone = '0;
        repeat (3) @(negedge clk);
        check("queue_drained", 32'(expQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
